async_handshake_ctrl: RTL and testbench

- Local-domain master for a 4-phase req/ack handshake with an external asynchronous agent, such as an off-chip peripheral or a foreign clock domain.
- Captures a data word on `start`, holds it stable on `data_out`, and drives `req_out`.
- Resynchronizes `ack_in` through an internal two-flop, reset-low synchronizer, then sequences request, release and return-to-idle.
- Aborts with a timeout if the acknowledge never arrives.

---
 rtl/async_handshake_ctrl.sv | 128 ++++++++++++
 tb/tb_async_handshake_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/async_handshake_ctrl.sv
// async_handshake_ctrl
//   Local-domain master of a 4-phase req/ack handshake with an asynchronous
//   external agent. A word is captured on an accepted start and held on
//   data_out while req_out is raised. ack_in passes through a two-flop
//   synchronizer; the FSM then releases req, waits for ack to fall and
//   returns to idle. If ack never arrives within TIMEOUT_CYCLES cycles of
//   REQ, the transfer is aborted.
//
// Ports
//   clk       in   system clock, rising edge
//   n_rst     in   asynchronous active-low reset
//   start     in   local request, sampled only in IDLE
//   data_in   in   [DATA_WIDTH] word captured on accept
//   ack_in    in   asynchronous acknowledge from the agent
//   req_out   out  registered 4-phase request
//   data_out  out  [DATA_WIDTH] held from accept until back in IDLE
//   busy      out  transaction in flight (including the done cycle)
//   done      out  one-cycle pulse on successful completion
//   timeout   out  one-cycle pulse on abort
module async_handshake_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ack_in,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, REQ, REL, ABORT} state_t;

  localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] CNT_ONE  = TO_WIDTH'(1);

  state_t                state, state_nxt;
  logic [TO_WIDTH-1:0]   cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  req_nxt, done_nxt, timeout_nxt;
  logic                  ack_meta, ack_sync;

  // Two-flop synchronizer; only ack_sync is seen by the FSM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= ack_in;
      ack_sync <= ack_meta;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_out  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      req_out  <= req_nxt;
      data_out <= data_nxt;
      done     <= done_nxt;
      timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    req_nxt     = req_out;
    data_nxt    = data_out;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        // A stale ack_sync here is deliberately ignored until start.
        if (start) begin
          data_nxt  = data_in;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        cnt_nxt = cnt + CNT_ONE;
        // Ack wins over a timeout landing in the same cycle.
        if (ack_sync) begin
          req_nxt   = 1'b0;
          state_nxt = REL;
        end else if (cnt == CNT_LAST) begin
          req_nxt     = 1'b0;
          timeout_nxt = 1'b1;
          state_nxt   = ABORT;
        end
      end
      REL: begin
        // No timeout here: the agent must eventually drop ack.
        if (!ack_sync) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      ABORT: begin
        // A late ack keeps us here until it falls again.
        if (!ack_sync) state_nxt = IDLE;
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // done is registered and lands in the first IDLE cycle; folding it in keeps
  // busy high through the done cycle so there is no gap.
  assign busy = (state != IDLE) | done;

endmodule

// File: tb/tb_async_handshake_ctrl.sv
// Directed bench for async_handshake_ctrl (TIMEOUT_CYCLES = 10).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_async_handshake_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [7:0] data_in;
  logic       ack_in;
  logic       req_out;
  logic [7:0] data_out;
  logic       busy, done, timeout;

  int nvec = 0;
  int nerr = 0;

  async_handshake_ctrl #(
    .DATA_WIDTH(8), .TIMEOUT_CYCLES(10), .TO_WIDTH(8)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in),
    .ack_in(ack_in), .req_out(req_out), .data_out(data_out),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset with start and ack both asserted
    n_rst = 1'b0; start = 1'b1; ack_in = 1'b1; data_in = 8'hFF;
    #23;
    chk("rst_req", req_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timeout, 0);
    @(posedge clk); #1;
    start = 1'b0; ack_in = 1'b0; n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_req", req_out, 0);
      chk("idle_busy", busy, 0);
    end

    // ---- normal transfer, agent acks 3 cycles after req
    start = 1'b1; data_in = 8'hA5;
    tick();                                   // accept edge
    start = 1'b0; data_in = 8'h00;
    chk("n_req", req_out, 1);
    chk("n_data", data_out, 8'hA5);
    chk("n_busy", busy, 1);
    tick(); tick(); tick();
    ack_in = 1'b1;
    tick(); chk("n_req_e1", req_out, 1);
    tick(); chk("n_req_e2", req_out, 1);
    tick(); chk("n_req_e3", req_out, 0);      // 3 edges after ack rise
    chk("n_data_rel", data_out, 8'hA5);
    tick(); tick();
    ack_in = 1'b0;
    tick(); chk("n_done_f1", done, 0); chk("n_busy_f1", busy, 1);
    tick(); chk("n_done_f2", done, 0);
    tick(); chk("n_done_f3", done, 1); chk("n_busy_done", busy, 1);
    chk("n_data_done", data_out, 8'hA5);
    tick(); chk("n_done_off", done, 0); chk("n_busy_off", busy, 0);

    // ---- timeout: req high exactly 10 cycles
    start = 1'b1; data_in = 8'h96;
    tick();
    start = 1'b0;
    chk("t_req0", req_out, 1);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("t_req", req_out, 1);
      chk("t_to_early", timeout, 0);
    end
    tick();
    chk("t_req_drop", req_out, 0);
    chk("t_pulse", timeout, 1);
    chk("t_nodone", done, 0);
    chk("t_data", data_out, 8'h96);
    tick();
    chk("t_pulse_off", timeout, 0);
    chk("t_idle", busy, 0);
    chk("t_nodone2", done, 0);

    // ---- ack_sync first high on the counter==9 evaluation edge
    start = 1'b1; data_in = 8'h4B;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    ack_in = 1'b1;
    tick();
    tick(); chk("c_req_pre", req_out, 1);
    tick();
    chk("c_req", req_out, 0);
    chk("c_no_to", timeout, 0);
    chk("c_busy", busy, 1);
    tick(); chk("c_no_to2", timeout, 0);
    ack_in = 1'b0;
    tick(); chk("c_done_f1", done, 0);
    tick(); chk("c_done_f2", done, 0);
    tick(); chk("c_done", done, 1); chk("c_to_done", timeout, 0);

    // ---- start while busy ignored, then back-to-back start on done cycle
    start = 1'b1; data_in = 8'h5A;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; data_in = 8'h3C;            // in REQ: ignored
    tick();
    start = 1'b0;
    chk("b_data_hold", data_out, 8'h5A);
    ack_in = 1'b1;
    tick(); tick();
    tick(); chk("b_req_rel", req_out, 0);
    ack_in = 1'b0;
    tick();
    start = 1'b1; data_in = 8'h77;            // held through done cycle
    tick();
    tick();
    chk("b_done", done, 1);
    chk("b_data_old", data_out, 8'h5A);
    tick();
    chk("b_data_new", data_out, 8'h77);
    chk("b_req_new", req_out, 1);
    chk("b_done_off", done, 0);
    start = 1'b0;

    // ---- async reset while in REL
    ack_in = 1'b1;
    tick(); tick(); tick();
    chk("r_in_rel", busy, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("r_req", req_out, 0);
    chk("r_busy", busy, 0);
    chk("r_data", data_out, 0);
    chk("r_done", done, 0);
    ack_in = 1'b0;
    tick();
    n_rst = 1'b1;
    tick(); chk("r_idle_req", req_out, 0);

    // ---- late ack: ack_sync rises during the first ABORT cycle
    start = 1'b1; data_in = 8'hC3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    ack_in = 1'b1;
    tick(); chk("l_req_pre", req_out, 1);
    tick();
    chk("l_to", timeout, 1);
    chk("l_req", req_out, 0);
    tick(); chk("l_abort1", busy, 1); chk("l_to_off", timeout, 0);
    tick(); chk("l_abort2", busy, 1);
    ack_in = 1'b0;
    tick(); chk("l_abort3", busy, 1);
    tick(); chk("l_abort4", busy, 1); chk("l_nodone_a", done, 0);
    tick(); chk("l_idle", busy, 0); chk("l_nodone", done, 0);
    chk("l_req_idle", req_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
